// File: rtl/edge_track_window.sv
// 3x3 sliding window over a raster stream of 2-bit edge-strength codes, with border masking.
// Optional EDGE_WINDOW_CODE_CHECK_EN: accepted code 11 is stored as 00 and raises sticky code_err.
module edge_track_window #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  strength_in,
    input  logic        strength_in_valid,
    output logic        in_ready,
    output logic [17:0] strength_value,
    output logic        strength_valid,
    output logic        code_err
);
    // Input side: a pixel moves on the cycle strength_in_valid && in_ready; in_ready depends
    // only on state. Output side: strength_valid is a one-cycle qualifier with no backpressure.
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int FW = $clog2(IMG_WIDTH + 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_d;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [FW-1:0] flush_cnt;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;

    // lb_near holds the previous row, lb_far the row before it, both indexed by column.
    logic [1:0] lb_near [IMG_WIDTH];
    logic [1:0] lb_far  [IMG_WIDTH];
    logic [1:0] win     [9];
    logic [1:0] win_d   [9];

    logic        accept;
    logic        advance;
    logic        emit;
    logic        col_last;
    logic        row_last;
    logic        flush_last;
    logic [1:0]  code_px;
    logic [1:0]  px;
    logic [17:0] win_masked;
    logic        top_off;
    logic        bot_off;
    logic        left_off;
    logic        right_off;

    assign in_ready   = (state != FLUSH);
    assign accept     = strength_in_valid && in_ready;
    assign advance    = accept || (state == FLUSH);
    assign emit       = (state == RUN && accept) || (state == FLUSH);
    assign col_last   = (col == CW'(IMG_WIDTH - 1));
    assign row_last   = (row == RW'(IMG_HEIGHT - 1));
    assign flush_last = (flush_cnt == FW'(IMG_WIDTH));

`ifdef EDGE_WINDOW_CODE_CHECK_EN
    assign code_px = (strength_in == 2'b11) ? 2'b00 : strength_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_err <= 1'b0;
        end else if (accept && strength_in == 2'b11) begin
            code_err <= 1'b1;
        end
    end
`else
    assign code_px  = strength_in;
    assign code_err = 1'b0;
`endif

    // Flush cycles push virtual 00 pixels so the last row of windows drains out.
    assign px = (state == FLUSH) ? 2'b00 : code_px;

    always_comb begin
        state_d = state;
        case (state)
            FILL:    if (accept && row == RW'(1) && col == '0) state_d = RUN;
            RUN:     if (accept && row_last && col_last) state_d = FLUSH;
            FLUSH:   if (flush_last) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            flush_cnt <= '0;
        end else if (state == FLUSH) begin
            if (flush_last) begin
                flush_cnt <= '0;
                col       <= '0;
                row       <= '0;
            end else begin
                flush_cnt <= flush_cnt + 1'b1;
                col       <= col_last ? '0 : col + 1'b1;
            end
        end else if (accept) begin
            col <= col_last ? '0 : col + 1'b1;
            if (col_last) begin
                row <= row_last ? '0 : row + 1'b1;
            end
        end
    end

    // New column enters on the right; the window centre lags the input by one row and one column.
    always_comb begin
        win_d[0] = win[1];
        win_d[1] = win[2];
        win_d[2] = lb_far[col];
        win_d[3] = win[4];
        win_d[4] = win[5];
        win_d[5] = lb_near[col];
        win_d[6] = win[7];
        win_d[7] = win[8];
        win_d[8] = px;
    end

    // Line buffers and window carry no reset; counters and FILL keep stale contents out of view.
    always_ff @(posedge clk) begin
        if (advance) begin
            lb_far[col]  <= lb_near[col];
            lb_near[col] <= px;
            for (int i = 0; i < 9; i++) begin
                win[i] <= win_d[i];
            end
        end
    end

    assign top_off   = (out_row == '0);
    assign bot_off   = (out_row == RW'(IMG_HEIGHT - 1));
    assign left_off  = (out_col == '0);
    assign right_off = (out_col == CW'(IMG_WIDTH - 1));

    // Masking also removes the wrapped column that belongs to the neighbouring row.
    always_comb begin
        win_masked = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!((r == 0 && top_off) || (r == 2 && bot_off) ||
                      (c == 0 && left_off) || (c == 2 && right_off))) begin
                    win_masked[2*(3*r+c) +: 2] = win_d[3*r+c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strength_value <= '0;
            strength_valid <= 1'b0;
            out_col        <= '0;
            out_row        <= '0;
        end else begin
            strength_valid <= emit;
            if (emit) begin
                strength_value <= win_masked;
                out_col        <= right_off ? '0 : out_col + 1'b1;
                if (right_off) begin
                    out_row <= bot_off ? '0 : out_row + 1'b1;
                end
            end
        end
    end

endmodule
